// File: rtl/imm_gen_pipe.sv
// Elastic-pipelined RV32I/RV64I immediate generator (I/S/B/U/J) with valid/ready and flush.
// Optional macro IMM_GEN_ILLEGAL_EN adds a pipelined out_illegal flag.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int PIPE_DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
`ifdef IMM_GEN_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    logic [XLEN-1:0]       imm_d;
    logic [2:0]            fmt_d;
    logic [PIPE_DEPTH-1:0] v;
    logic [PIPE_DEPTH-1:0] room;
    logic                  full_tail;
    logic [XLEN-1:0]       imm_q [PIPE_DEPTH];
    logic [2:0]            fmt_q [PIPE_DEPTH];

    // Shift-immediate forms carry a zero-extended shamt instead of a signed immediate.
    always_comb begin
        imm_d = '0;
        fmt_d = FMT_NONE;
        case (in_instr[6:0])
            OPC_LOAD, OPC_JALR: begin
                fmt_d = FMT_I;
                imm_d = XLEN'($signed(in_instr[31:20]));
            end
            OPC_OP_IMM: begin
                fmt_d = FMT_I;
                if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                    imm_d = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
                else
                    imm_d = XLEN'($signed(in_instr[31:20]));
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt_d = FMT_I;
                    if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101)
                        imm_d = XLEN'(in_instr[24:20]);
                    else
                        imm_d = XLEN'($signed(in_instr[31:20]));
                end
            end
            OPC_STORE: begin
                fmt_d = FMT_S;
                imm_d = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt_d = FMT_B;
                imm_d = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_d = FMT_U;
                imm_d = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt_d = FMT_J;
                imm_d = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
            end
            default: begin
                fmt_d = FMT_NONE;
                imm_d = '0;
            end
        endcase
    end

    // Stage k can load when any stage from k to the output is empty, or the output drains.
    always_comb begin
        full_tail = 1'b1;
        room      = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            full_tail = full_tail & v[k];
            room[k]   = out_ready | ~full_tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            if (room[0])
                v[0] <= in_valid;
            for (int k = 1; k < PIPE_DEPTH; k++)
                if (room[k])
                    v[k] <= v[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                imm_q[k] <= '0;
                fmt_q[k] <= FMT_NONE;
            end
        end else begin
            if (room[0] && in_valid) begin
                imm_q[0] <= imm_d;
                fmt_q[0] <= fmt_d;
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (room[k] && v[k-1]) begin
                    imm_q[k] <= imm_q[k-1];
                    fmt_q[k] <= fmt_q[k-1];
                end
            end
        end
    end

`ifdef IMM_GEN_ILLEGAL_EN
    logic ill_d;
    logic ill_q [PIPE_DEPTH];

    always_comb begin
        ill_d = (in_instr[1:0] != 2'b11) || (fmt_d == FMT_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_DEPTH; k++)
                ill_q[k] <= 1'b0;
        end else begin
            if (room[0] && in_valid)
                ill_q[0] <= ill_d;
            for (int k = 1; k < PIPE_DEPTH; k++)
                if (room[k] && v[k-1])
                    ill_q[k] <= ill_q[k-1];
        end
    end

    assign out_illegal = ill_q[PIPE_DEPTH-1];
`endif

    assign in_ready  = room[0];
    assign out_valid = v[PIPE_DEPTH-1];
    assign out_imm   = imm_q[PIPE_DEPTH-1];
    assign out_fmt   = fmt_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a reference model predicts each accepted instruction,
// and a monitor pops and compares on every output handshake. Honours IMM_GEN_ILLEGAL_EN.
module tb_imm_gen_pipe;

    localparam int XLEN       = 64;
    localparam int PIPE_DEPTH = 3;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
    logic            out_illegal;
`endif

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    bit              hold_pending = 1'b0;
    logic [XLEN-1:0] held_imm;
    logic [2:0]      held_fmt;

    imm_gen_pipe #(.XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt)
`ifdef IMM_GEN_ILLEGAL_EN
        ,
        .out_illegal (out_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Interpret a raw field as a bits-wide two's complement number, then wrap to XLEN.
    function automatic logic [XLEN-1:0] sext(input longint unsigned raw, input int bits);
        longint val;
        val = longint'(raw);
        if (raw >= (64'd1 << (bits - 1)))
            val = val - longint'(64'd1 << bits);
        return val[XLEN-1:0];
    endfunction

    function automatic exp_t ref_model(input logic [31:0] instr);
        exp_t e;
        longint unsigned w;
        int f3;
        e  = '0;
        w  = 64'(instr);
        f3 = int'((w >> 12) % 8);
        case (instr[6:0])
            7'h03, 7'h67: begin
                e.fmt = 3'd1;
                e.imm = sext(w >> 20, 12);
            end
            7'h13: begin
                e.fmt = 3'd1;
                if (f3 == 1 || f3 == 5)
                    e.imm = (XLEN == 64) ? XLEN'((w >> 20) % 64) : XLEN'((w >> 20) % 32);
                else
                    e.imm = sext(w >> 20, 12);
            end
            7'h1B: begin
                if (XLEN == 64) begin
                    e.fmt = 3'd1;
                    if (f3 == 1 || f3 == 5)
                        e.imm = XLEN'((w >> 20) % 32);
                    else
                        e.imm = sext(w >> 20, 12);
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                e.imm = sext(((w >> 25) << 5) + ((w >> 7) % 32), 12);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = sext(((w >> 31) << 12) + (((w >> 7) % 2) << 11) +
                             (((w >> 25) % 64) << 5) + (((w >> 8) % 16) << 1), 13);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = sext(w - (w % 4096), 32);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                e.imm = sext(((w >> 31) << 20) + (((w >> 12) % 256) << 12) +
                             (((w >> 20) % 2) << 11) + (((w >> 21) % 1024) << 1), 21);
            end
            default: e = '0;
        endcase
`ifdef IMM_GEN_ILLEGAL_EN
        e.ill = (w % 4 != 3) || (e.fmt == 3'd0);
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  r[6:0] = 7'h03;
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h1B;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h23;
            5:  r[6:0] = 7'h63;
            6:  r[6:0] = 7'h37;
            7:  r[6:0] = 7'h17;
            8:  r[6:0] = 7'h6F;
            9:  r[14:12] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
            10: r = 32'h0;
            default: ;
        endcase
        if (r[6:0] == 7'h00 && r != 32'h0)
            r[6:0] = 7'h13;
        return r;
    endfunction

    // Predict at the edge where the transfer happens; a flush kills everything still queued.
    always @(posedge clk) begin
        if (rst_n) begin
            if (flush)
                sb_q.delete();
            else if (in_valid && in_ready)
                sb_q.push_back(ref_model(in_instr));
        end
    end

    // Monitor: inputs are stable from posedge+1, so sampling here reflects the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_output("hold_valid", 64'(out_valid), 64'd1);
                check_output("hold_imm", 64'(out_imm), 64'(held_imm));
                check_output("hold_fmt", 64'(out_fmt), 64'(held_fmt));
            end
            hold_pending = 1'b0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_output("out_imm", 64'(out_imm), 64'(e.imm));
                    check_output("out_fmt", 64'(out_fmt), 64'(e.fmt));
`ifdef IMM_GEN_ILLEGAL_EN
                    check_output("out_illegal", 64'(out_illegal), 64'(e.ill));
`endif
                end
            end else if (out_valid && !flush) begin
                hold_pending = 1'b1;
                held_imm     = out_imm;
                held_fmt     = out_fmt;
            end
        end
    end

    task automatic apply_stimulus(input logic valid, input logic [31:0] instr,
                                  input logic fl, input logic rdy, output bit acc);
        in_valid  = valid;
        in_instr  = instr;
        flush     = fl;
        out_ready = rdy;
        @(negedge clk);
        acc = valid && in_ready && !fl && rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acc;
        int          idx;
        int          n_out;
        logic [31:0] bp_list [6];
        logic [31:0] dir_list [4];

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_out_imm", 64'(out_imm), 64'd0);
        check_output("reset_out_fmt", 64'(out_fmt), 64'd0);
`ifdef IMM_GEN_ILLEGAL_EN
        check_output("reset_out_illegal", 64'(out_illegal), 64'd0);
`endif
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single instruction through an empty pipe.
        apply_stimulus(1'b1, 32'hFFF00093, 1'b0, 1'b1, acc);
        check_output("addi_accept", 64'(acc), 64'd1);
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            check_output("latency_early", 64'(out_valid), 64'd0);
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, acc);
        end
        check_output("latency_arrive", 64'(out_valid), 64'd1);
        idle(PIPE_DEPTH + 1);

        dir_list[0] = 32'hFE112E23;
        dir_list[1] = 32'hFE000CE3;
        dir_list[2] = 32'h123450B7;
        dir_list[3] = 32'h4030D093;
        idx = 0;
        while (idx < 4) begin
            apply_stimulus(1'b1, dir_list[idx], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        idle(PIPE_DEPTH + 1);

        // Backpressure: pipe fills to PIPE_DEPTH, then drains at one per cycle.
        for (int i = 0; i < 6; i++)
            bp_list[i] = rand_instr();
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, bp_list[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check_output("bp_accepted", 64'(idx), 64'(PIPE_DEPTH));
        check_output("bp_in_ready", 64'(in_ready), 64'd0);
        n_out = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) n_out++;
            apply_stimulus(idx < 6, bp_list[idx < 6 ? idx : 0], 1'b0, 1'b1, acc);
            if (acc) idx++;
        end
        check_output("bp_throughput", 64'(n_out), 64'd6);
        check_output("bp_all_accepted", 64'(idx), 64'd6);
        idle(PIPE_DEPTH + 1);

        // Flush with a full pipe and a simultaneous input.
        for (int i = 0; i < PIPE_DEPTH; i++)
            apply_stimulus(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        check_output("pre_flush_valid", 64'(out_valid), 64'd1);
        apply_stimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0, acc);
        check_output("flush_out_valid", 64'(out_valid), 64'd0);
        check_output("flush_in_ready", 64'(in_ready), 64'd1);
        idle(PIPE_DEPTH + 2);

        // Undecodable words.
        apply_stimulus(1'b1, 32'h00000000, 1'b0, 1'b1, acc);
        apply_stimulus(1'b1, 32'hFFF00091, 1'b0, 1'b1, acc);
        apply_stimulus(1'b1, 32'h0000007F, 1'b0, 1'b1, acc);
        idle(PIPE_DEPTH + 1);

        // Asynchronous reset in the middle of a stalled stream.
        for (int i = 0; i < 2; i++)
            apply_stimulus(1'b1, rand_instr(), 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_output("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_mid_in_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(PIPE_DEPTH + 2);

        // Random traffic with backpressure and occasional flushes.
        for (int i = 0; i < 3000; i++)
            apply_stimulus($urandom_range(0, 3) != 0, rand_instr(),
                           $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, acc);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++)
            apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, acc);
        check_output("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
